ch0re_mem_arbiter: RTL

CH0RE_MEM_ARBITER -- requirements
Module: ch0re_mem_arbiter

---
 rtl/ch0re_mem_arbiter_pkg.sv | 35 +++
 rtl/ch0re_resp_pipe.sv | 45 ++++
 rtl/ch0re_mem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ch0re_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ch0re_mem_arbiter_pkg
// Description : Shared types for the ch0re memory arbiter: the owner enum,
//               the response tag carried through the read-latency pipe, and
//               a helper that drops fetch tags on a flush.
// Revision    : 1.0 - initial release
// ============================================================================
package ch0re_mem_arbiter_pkg;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } mem_owner_e;

    typedef struct packed {
        logic       valid;
        mem_owner_e owner;
        logic       addr2;
    } resp_tag_t;

    localparam resp_tag_t c_TAG_IDLE = '{valid: 1'b0, owner: OWNER_IF, addr2: 1'b0};

    // A flush kills only fetch entries; load/store entries pass untouched.
    function automatic resp_tag_t flush_kill(input resp_tag_t tag, input logic flush);
        resp_tag_t r;
        r = tag;
        if (flush && (tag.owner == OWNER_IF)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ch0re_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ch0re_resp_pipe
// Description : MEM_LAT-deep shift register of read tags that lines up each
//               read grant with the memory data returning MEM_LAT cycles
//               later. Fetch entries are killed while i_flush is high.
// Revision    : 1.0 - initial release
// ============================================================================
module ch0re_resp_pipe
    import ch0re_mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
)(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  resp_tag_t i_tag,
    output resp_tag_t o_tag
);

    // w_chain[0] is the tag being granted now, w_chain[k] is the tag granted k cycles ago
    resp_tag_t w_chain [MEM_LAT+1];

    assign w_chain[0] = i_tag;

    for (genvar g = 0; g < MEM_LAT; g++) begin : g_stage
        resp_tag_t r_tag;

        // Advance one stage per cycle, dropping fetch entries during a flush
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_tag <= c_TAG_IDLE;
            end else begin
                r_tag <= flush_kill(w_chain[g], i_flush);
            end
        end

        assign w_chain[g+1] = r_tag;
    end

    // The exiting entry is also masked so a flush silences the fetch response that same cycle
    assign o_tag = flush_kill(w_chain[MEM_LAT], i_flush);

endmodule
`default_nettype wire

// File: rtl/ch0re_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ch0re_mem_arbiter
// Description : Two-requester (fetch / load-store) arbiter in front of a
//               single-port doubleword memory. Combinational grants with
//               last-grant alternation, in-order read response tagging,
//               fetch flush, and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ch0re_mem_arbiter
    import ch0re_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_LAT    = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [63:0]           i_if_addr,
    input  logic                  i_if_flush,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [31:0]           o_if_rdata,
    input  logic                  i_ls_req,
    input  logic [63:0]           i_ls_addr,
    input  logic [7:0]            i_ls_wen,
    input  logic [63:0]           i_ls_wdata,
    output logic                  o_ls_gnt,
    output logic                  o_ls_rvalid,
    output logic [63:0]           o_ls_rdata,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [7:0]            o_mem_wen,
    output logic [63:0]           o_mem_wdata,
    input  logic [63:0]           i_mem_rdata,
    output logic [31:0]           o_stall_cnt
);

    mem_owner_e  r_lg;
    logic [31:0] r_stall_cnt;
    logic        w_if_cand;
    logic        w_ls_cand;
    logic        w_if_gnt;
    logic        w_ls_gnt;
    logic        w_stall;
    resp_tag_t   w_tag_in;
    resp_tag_t   w_tag_out;

    // Byte-offset bits and bits above the memory range are dropped by design
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, i_if_addr[63:ADDR_WIDTH+3], i_if_addr[1:0],
                                  i_ls_addr[63:ADDR_WIDTH+3], i_ls_addr[1:0]};

    // A flushing fetch side competes as if idle; nothing is granted in reset
    assign w_if_cand = i_if_req && !i_if_flush && !rst;
    assign w_ls_cand = i_ls_req && !rst;
    assign w_ls_gnt  = w_ls_cand && (!w_if_cand || (r_lg == OWNER_IF));
    assign w_if_gnt  = w_if_cand && !w_ls_gnt;
    assign o_if_gnt  = w_if_gnt;
    assign o_ls_gnt  = w_ls_gnt;

    // Steer the winner onto the memory port and build its response tag
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wen   = 8'h00;
        o_mem_wdata = 64'h0;
        w_tag_in    = c_TAG_IDLE;
        if (w_ls_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_addr  = i_ls_addr[ADDR_WIDTH+2:3];
            o_mem_wen   = i_ls_wen;
            o_mem_wdata = i_ls_wdata;
            w_tag_in    = '{valid: (i_ls_wen == 8'h00), owner: OWNER_LS, addr2: i_ls_addr[2]};
        end else if (w_if_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_addr  = i_if_addr[ADDR_WIDTH+2:3];
            w_tag_in    = '{valid: 1'b1, owner: OWNER_IF, addr2: i_if_addr[2]};
        end
    end

    // Remember the last winner so that contention alternates between requesters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lg <= OWNER_IF;
        end else if (w_if_gnt) begin
            r_lg <= OWNER_IF;
        end else if (w_ls_gnt) begin
            r_lg <= OWNER_LS;
        end
    end

    // Count cycles where some asserted request went unserved, holding at all-ones
    assign w_stall = (i_if_req && !w_if_gnt) || (i_ls_req && !w_ls_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'h0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

    ch0re_resp_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_if_flush),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    // Route returning memory data to the owner recorded in the tag
    assign o_if_rvalid = w_tag_out.valid && (w_tag_out.owner == OWNER_IF);
    assign o_ls_rvalid = w_tag_out.valid && (w_tag_out.owner == OWNER_LS);
    assign o_ls_rdata  = rst ? 64'h0 : i_mem_rdata;
    assign o_if_rdata  = rst ? 32'h0 : (w_tag_out.addr2 ? i_mem_rdata[63:32] : i_mem_rdata[31:0]);

endmodule
`default_nettype wire
